// File: rtl/noc_arb_pkg.sv
// Shared types and the round-robin pick helper for the NoC tx arbiter.
package noc_arb_pkg;

    // Widest source vector the pick helper can scan.
    localparam int unsigned RR_MAX_SRC = 32;
    localparam int unsigned RR_IDXW    = 5;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    typedef struct packed {
        logic               found;
        logic [RR_IDXW-1:0] idx;
    } rr_pick_t;

    // First requester at or after ptr, wrapping modulo num (ptr < num <= RR_MAX_SRC).
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_SRC-1:0] req,
                                         input logic [RR_IDXW-1:0]    ptr,
                                         input int unsigned           num);
        rr_pick_t    r;
        int unsigned cand;
        r = '0;
        for (int unsigned i = 0; i < RR_MAX_SRC; i++) begin
            if ((i < num) && !r.found) begin
                cand = 32'(ptr) + i;
                if (cand >= num) cand = cand - num;
                if (req[cand[RR_IDXW-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = cand[RR_IDXW-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: request vector and priority pointer
// in, one-hot grant and winner index out.
module rr_arbiter
    import noc_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IDXW    = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDXW-1:0]    ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDXW-1:0]    idx
);

    logic [RR_MAX_SRC-1:0] req_ext;
    logic [RR_IDXW-1:0]    ptr_ext;
    rr_pick_t              pick;

    assign req_ext = RR_MAX_SRC'(req);
    assign ptr_ext = RR_IDXW'(ptr);
    assign pick    = rr_pick(req_ext, ptr_ext, NUM_SRC);
    assign idx     = IDXW'(pick.idx);

    // Expand the picked index into a one-hot grant (all zero when nothing requests).
    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            grant[i] = pick.found && (pick.idx == RR_IDXW'(i));
        end
    end

endmodule

// File: rtl/noc_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-S NoC tx port among
// NUM_SRC sources, with a one-beat registered output slice.
module noc_tx_arbiter
    import noc_arb_pkg::*;
#(
    parameter  int unsigned NUM_SRC   = 4,
    parameter  int unsigned DATAW     = 512,
    parameter  int unsigned USERW     = 75,
    parameter  int unsigned DATAUSERW = DATAW + USERW,
    parameter  int unsigned BYTEW     = 8,
    parameter  int unsigned IDW       = 32,
    parameter  int unsigned DESTW     = 7,
    parameter  int unsigned CNTW      = 16,
    localparam int unsigned IDXW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC-1:0]           src_tvalid,
    input  logic [NUM_SRC*DATAUSERW-1:0] src_tdata,
    input  logic [NUM_SRC*DESTW-1:0]     src_tdest,
    input  logic [NUM_SRC-1:0]           src_tlast,
    output logic [NUM_SRC-1:0]           src_tready,
    output logic                         axis_tx_tvalid,
    output logic [DATAUSERW-1:0]         axis_tx_tdata,
    output logic [BYTEW-1:0]             axis_tx_tstrb,
    output logic [BYTEW-1:0]             axis_tx_tkeep,
    output logic [IDW-1:0]               axis_tx_tid,
    output logic [DESTW-1:0]             axis_tx_tdest,
    output logic [USERW-1:0]             axis_tx_tuser,
    output logic                         axis_tx_tlast,
    input  logic                         axis_tx_tready,
    output logic [IDXW-1:0]              owner,
    output logic                         busy,
    output logic [CNTW-1:0]              pkt_count
);

    if ((DATAUSERW != DATAW + USERW) || (NUM_SRC < 1) || (NUM_SRC > RR_MAX_SRC)) begin : g_param_check
        $error("noc_tx_arbiter: inconsistent parameters");
    end

    arb_state_t           state;
    logic [IDXW-1:0]      rr_ptr;
    logic [IDXW-1:0]      owner_q;

    logic [NUM_SRC-1:0]   arb_grant;
    logic [IDXW-1:0]      arb_idx;
    logic [NUM_SRC-1:0]   grant;
    logic [IDXW-1:0]      sel_idx;
    logic                 load_ok;
    logic                 acc;
    logic                 acc_last;
    logic [DATAUSERW-1:0] sel_data;
    logic [DESTW-1:0]     sel_dest;

    logic                 tx_valid;
    logic [DATAUSERW-1:0] tx_data;
    logic [IDW-1:0]       tx_id;
    logic [DESTW-1:0]     tx_dest;
    logic                 tx_last;
    logic [CNTW-1:0]      pkt_cnt_q;

    function automatic logic [IDXW-1:0] rr_next(input logic [IDXW-1:0] i);
        return (i == IDXW'(NUM_SRC - 1)) ? '0 : i + IDXW'(1);
    endfunction

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDXW    (IDXW)
    ) u_rr (
        .req   (src_tvalid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign load_ok = ~tx_valid | axis_tx_tready;
    assign sel_idx = (state == ARB_IDLE) ? arb_idx : owner_q;

    // Select the granted source: arbiter winner in IDLE, locked owner otherwise.
    always_comb begin
        grant = '0;
        if (state == ARB_IDLE) begin
            grant = arb_grant;
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                grant[i] = (owner_q == IDXW'(i));
            end
        end
    end

    // Ready is also gated by reset so no source sees an accept while held in reset.
    assign src_tready = grant & {NUM_SRC{load_ok & rst}};
    assign acc        = |(src_tvalid & src_tready);

    // Multiplex the selected source's beat fields.
    always_comb begin
        sel_data = '0;
        sel_dest = '0;
        acc_last = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (sel_idx == IDXW'(i)) begin
                sel_data = src_tdata[i*DATAUSERW +: DATAUSERW];
                sel_dest = src_tdest[i*DESTW +: DESTW];
                acc_last = src_tlast[i];
            end
        end
    end

    // Output register slice: load on accept, hold under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_id    <= '0;
            tx_dest  <= '0;
            tx_last  <= 1'b0;
        end else if (load_ok) begin
            tx_valid <= acc;
            if (acc) begin
                tx_data <= sel_data;
                tx_id   <= IDW'(sel_idx);
                tx_dest <= sel_dest;
                tx_last <= acc_last;
            end
        end
    end

    // Packet lock FSM and round-robin pointer update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            rr_ptr  <= '0;
            owner_q <= '0;
        end else if (acc) begin
            owner_q <= sel_idx;
            if (acc_last) begin
                state  <= ARB_IDLE;
                rr_ptr <= rr_next(sel_idx);
            end else begin
                state  <= ARB_LOCKED;
            end
        end
    end

    // Wrapping count of accepted tlast beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt_q <= '0;
        end else if (acc && acc_last) begin
            pkt_cnt_q <= pkt_cnt_q + CNTW'(1);
        end
    end

    assign axis_tx_tvalid = tx_valid;
    assign axis_tx_tdata  = tx_data;
    assign axis_tx_tstrb  = {BYTEW{tx_valid}};
    assign axis_tx_tkeep  = {BYTEW{tx_valid}};
    assign axis_tx_tid    = tx_id;
    assign axis_tx_tdest  = tx_dest;
    assign axis_tx_tuser  = tx_data[DATAUSERW-1 -: USERW];
    assign axis_tx_tlast  = tx_last;
    assign owner          = owner_q;
    assign busy           = (state == ARB_LOCKED);
    assign pkt_count      = pkt_cnt_q;

endmodule

// File: tb/tb_noc_tx_arbiter.sv
// Directed self-checking bench for noc_tx_arbiter (4 sources, 4-bit packet counter).
module tb_noc_tx_arbiter;

    localparam int NS  = 4;
    localparam int DW  = 512;
    localparam int UW  = 75;
    localparam int DUW = DW + UW;
    localparam int BW  = 8;
    localparam int IW  = 32;
    localparam int DSW = 7;
    localparam int CW  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     src_tvalid;
    logic [NS*DUW-1:0] src_tdata;
    logic [NS*DSW-1:0] src_tdest;
    logic [NS-1:0]     src_tlast;
    logic [NS-1:0]     src_tready;
    logic              axis_tx_tvalid;
    logic [DUW-1:0]    axis_tx_tdata;
    logic [BW-1:0]     axis_tx_tstrb;
    logic [BW-1:0]     axis_tx_tkeep;
    logic [IW-1:0]     axis_tx_tid;
    logic [DSW-1:0]    axis_tx_tdest;
    logic [UW-1:0]     axis_tx_tuser;
    logic              axis_tx_tlast;
    logic              axis_tx_tready;
    logic [1:0]        owner;
    logic              busy;
    logic [CW-1:0]     pkt_count;

    int tests = 0;
    int fails = 0;

    noc_tx_arbiter #(
        .NUM_SRC (NS), .DATAW (DW), .USERW (UW), .DATAUSERW (DUW),
        .BYTEW (BW), .IDW (IW), .DESTW (DSW), .CNTW (CW)
    ) dut (
        .clk (clk), .rst (rst),
        .src_tvalid (src_tvalid), .src_tdata (src_tdata), .src_tdest (src_tdest),
        .src_tlast (src_tlast), .src_tready (src_tready),
        .axis_tx_tvalid (axis_tx_tvalid), .axis_tx_tdata (axis_tx_tdata),
        .axis_tx_tstrb (axis_tx_tstrb), .axis_tx_tkeep (axis_tx_tkeep),
        .axis_tx_tid (axis_tx_tid), .axis_tx_tdest (axis_tx_tdest),
        .axis_tx_tuser (axis_tx_tuser), .axis_tx_tlast (axis_tx_tlast),
        .axis_tx_tready (axis_tx_tready),
        .owner (owner), .busy (busy), .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [DUW-1:0] d,
                           input logic [DSW-1:0] dst, input logic l);
        src_tvalid[i]            = v;
        src_tdata[i*DUW +: DUW]  = d;
        src_tdest[i*DSW +: DSW]  = dst;
        src_tlast[i]             = l;
    endtask

    logic [DUW-1:0] d;
    logic [DUW-1:0] prev_data;
    logic           src_fire, out_fire, hold, in_pkt;
    logic [IW-1:0]  pkt_tid;
    int             sent, rcvd;

    initial begin
        rst = 1'b0;
        src_tvalid = '1; src_tdata = '0; src_tdest = '0; src_tlast = '1;
        axis_tx_tready = 1'b0;

        // Reset state, with every source requesting.
        tick(); tick();
        chk("rst_tvalid", axis_tx_tvalid, 0);
        chk("rst_tdata", axis_tx_tdata, 0);
        chk("rst_tstrb", axis_tx_tstrb, 0);
        chk("rst_src_tready", src_tready, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_owner_busy", {owner, busy}, 0);

        // T1: single beat from s0.
        src_tvalid = '0; src_tlast = '0;
        rst = 1'b1;
        axis_tx_tready = 1'b1;
        set_src(0, 1'b1, DUW'(8'hA5), 7'd3, 1'b1);
        #1;
        chk("t1_src_tready", src_tready, 4'b0001);
        tick();
        set_src(0, 1'b0, '0, '0, 1'b0);
        chk("t1_tvalid", axis_tx_tvalid, 1);
        chk("t1_tdata", axis_tx_tdata, 8'hA5);
        chk("t1_tid", axis_tx_tid, 0);
        chk("t1_tdest", axis_tx_tdest, 3);
        chk("t1_tlast", axis_tx_tlast, 1);
        chk("t1_tstrb_tkeep", {axis_tx_tstrb, axis_tx_tkeep}, 16'hFFFF);
        chk("t1_pkt_count", pkt_count, 1);
        tick();
        chk("t1_drain_tvalid", axis_tx_tvalid, 0);

        // T2: all sources request single-beat packets; pointer is 1 after T1.
        for (int i = 0; i < NS; i++) begin
            d = DUW'(i + 1) << DW;
            d[7:0] = 8'(8'h20 + i);
            set_src(i, 1'b1, d, 7'(i + 4), 1'b1);
        end
        #1;
        chk("t2_first_grant", src_tready, 4'b0010);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 7) src_tvalid = '0;
            chk("t2_tvalid", axis_tx_tvalid, 1);
            chk("t2_tid", axis_tx_tid, (1 + k) % 4);
            chk("t2_tdest", axis_tx_tdest, ((1 + k) % 4) + 4);
            chk("t2_tuser", axis_tx_tuser, ((1 + k) % 4) + 1);
        end
        chk("t2_pkt_count", pkt_count, 9);
        tick();
        chk("t2_drain", axis_tx_tvalid, 0);

        // T3: s1 3-beat packet with a 2-cycle gap; s2 waits until s1's tlast.
        set_src(1, 1'b1, DUW'(8'h11), 7'd1, 1'b0);
        set_src(2, 1'b1, DUW'(8'h22), 7'd2, 1'b1);
        #1;
        chk("t3_grant_s1", src_tready, 4'b0010);
        tick();
        set_src(1, 1'b0, '0, 7'd1, 1'b0);
        chk("t3_b1_data", axis_tx_tdata, 8'h11);
        chk("t3_busy_owner", {busy, owner}, 3'b1_01);
        #1;
        chk("t3_gap1_ready", src_tready, 4'b0010);
        tick();
        chk("t3_gap_tvalid", axis_tx_tvalid, 0);
        chk("t3_gap_busy", busy, 1);
        tick();
        chk("t3_gap2_busy", busy, 1);
        set_src(1, 1'b1, DUW'(8'h12), 7'd1, 1'b0);
        tick();
        chk("t3_b2", {axis_tx_tid[1:0], axis_tx_tdata[7:0]}, 10'h1_12);
        set_src(1, 1'b1, DUW'(8'h13), 7'd1, 1'b1);
        tick();
        set_src(1, 1'b0, '0, '0, 1'b0);
        chk("t3_b3", {axis_tx_tid[1:0], axis_tx_tdata[7:0], axis_tx_tlast}, 11'b01_00010011_1);
        chk("t3_unlock", busy, 0);
        #1;
        chk("t3_grant_s2", src_tready, 4'b0100);
        tick();
        set_src(2, 1'b0, '0, '0, 1'b0);
        chk("t3_s2", {axis_tx_tid[1:0], axis_tx_tdata[7:0]}, 10'h2_22);
        chk("t3_pkt_count", pkt_count, 11);
        tick();

        // T4: s0 streams while the NoC stalls for cycles 4..8.
        sent = 0; rcvd = 0;
        for (int c = 0; c < 25; c++) begin
            axis_tx_tready = !(c >= 4 && c < 9);
            set_src(0, c < 20, DUW'(32'h100 + sent), 7'd5, 1'b1);
            #1;
            src_fire  = src_tvalid[0] & src_tready[0];
            out_fire  = axis_tx_tvalid & axis_tx_tready;
            hold      = axis_tx_tvalid & ~axis_tx_tready;
            prev_data = axis_tx_tdata;
            if (hold) chk("t4_stall_ready", src_tready, 0);
            tick();
            if (src_fire) sent++;
            if (out_fire) begin
                chk("t4_order", prev_data, 32'h100 + rcvd);
                rcvd++;
            end
            if (hold) chk("t4_held", axis_tx_tdata, prev_data);
        end
        chk("t4_sent", sent, 15);
        chk("t4_rcvd", rcvd, 15);
        chk("t4_pkt_count", pkt_count, 10);

        // T5: async reset while s3 holds the port.
        set_src(3, 1'b1, DUW'(8'h33), 7'd6, 1'b0);
        #1;
        chk("t5_grant_s3", src_tready, 4'b1000);
        tick();
        chk("t5_locked", {busy, owner, axis_tx_tvalid}, 4'b1_11_1);
        #2 rst = 1'b0;
        #1;
        chk("t5_tvalid", axis_tx_tvalid, 0);
        chk("t5_tdata_tid", {axis_tx_tdata, axis_tx_tid}, 0);
        chk("t5_tstrb_tlast", {axis_tx_tstrb, axis_tx_tlast}, 0);
        chk("t5_state", {busy, owner}, 0);
        chk("t5_pkt_count", pkt_count, 0);
        chk("t5_src_tready", src_tready, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < NS; i++) set_src(i, 1'b1, DUW'(8'h40 + i), 7'd0, 1'b1);
        #1;
        chk("t5_ptr_zero", src_tready, 4'b0001);
        tick();
        src_tvalid = '0;
        chk("t5_tid", axis_tx_tid, 0);
        chk("t5_pkt_after", pkt_count, 1);
        tick();

        // T6: 16 more packets (17 since reset) wrap the 4-bit counter to 1.
        set_src(2, 1'b1, DUW'(8'h66), 7'd2, 1'b1);
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 14) chk("t6_wrap_zero", pkt_count, 0);
        end
        src_tvalid = '0;
        chk("t6_pkt_count", pkt_count, 1);
        tick();

        // Random soak: one-hot ready and no packet interleaving on the output.
        in_pkt = 1'b0; pkt_tid = '0;
        for (int c = 0; c < 300; c++) begin
            src_tvalid     = NS'($urandom);
            src_tlast      = NS'($urandom);
            axis_tx_tready = ($urandom_range(0, 3) != 0);
            #1;
            chk("soak_onehot", $onehot0(src_tready), 1);
            if (axis_tx_tvalid && axis_tx_tready) begin
                if (in_pkt) chk("soak_interleave", axis_tx_tid, pkt_tid);
                in_pkt  = !axis_tx_tlast;
                pkt_tid = axis_tx_tid;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
